// File: rtl/msd_pkg.sv
// Shared types and constants for the matrix-by-scalar sequential divider.
package msd_pkg;

  localparam int DEF_W = 8;
  localparam int DEF_N = 9;

  // Every quotient bit is set when the job's divisor is zero.
  localparam logic DBZ_QUOT_BIT = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    ZERO = 2'd2,
    HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/serial_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, conditionally subtract.
module serial_div_step #(
  parameter int W = 8
) (
  input  logic [W:0]   rem_in,
  input  logic         bit_in,
  input  logic [W-1:0] divisor,
  output logic [W:0]   rem_out,
  output logic         q_bit
);

  logic [W:0] shifted;

  assign shifted = {rem_in[W-1:0], bit_in};
  // rem_in stays below the divisor, so its top bit only matters if that invariant breaks.
  assign q_bit   = rem_in[W] | (shifted >= {1'b0, divisor});
  assign rem_out = q_bit ? (shifted - {1'b0, divisor}) : shifted;

endmodule

// File: rtl/matrix_scalar_divider_seq.sv
// Time-shares one restoring bit-serial divider over N elements sharing a single divisor.
module matrix_scalar_divider_seq
  import msd_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int N = DEF_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] mat_in,
  input  logic [W-1:0]   scalar_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] quot_out,
  output logic [N*W-1:0] rem_out,
  output logic           div_by_zero
);

  localparam int CNT_W = $clog2(W + 1);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // out_valid and its data stay put until that edge, in_ready is high only while IDLE.

  state_t           state;
  logic [N*W-1:0]   mat_r;
  logic [W-1:0]     div_r;
  logic [W-1:0]     sh_r;
  logic [W:0]       prem_r;
  logic [CNT_W-1:0] bit_cnt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] next_idx;
  logic [W:0]       step_rem;
  logic             q_bit;

  assign next_idx = idx + 1'b1;

  // sh_r feeds dividend bits out of its MSB while quotient bits enter at its LSB,
  // so after W steps it holds the element's quotient.
  serial_div_step #(.W(W)) u_step (
    .rem_in  (prem_r),
    .bit_in  (sh_r[W-1]),
    .divisor (div_r),
    .rem_out (step_rem),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quot_out    <= '0;
      rem_out     <= '0;
      div_by_zero <= 1'b0;
      mat_r       <= '0;
      div_r       <= '0;
      sh_r        <= '0;
      prem_r      <= '0;
      bit_cnt     <= '0;
      idx         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mat_r    <= mat_in;
            div_r    <= scalar_in;
            sh_r     <= mat_in[W-1:0];
            prem_r   <= '0;
            bit_cnt  <= '0;
            idx      <= '0;
            in_ready <= 1'b0;
            if (scalar_in != '0) begin
              div_by_zero <= 1'b0;
              state       <= DIV;
            end else begin
              state <= ZERO;
            end
          end
        end
        DIV: begin
          if (bit_cnt == LAST_BIT) begin
            quot_out[idx*W +: W] <= {sh_r[W-2:0], q_bit};
            rem_out[idx*W +: W]  <= step_rem[W-1:0];
            prem_r  <= '0;
            bit_cnt <= '0;
            if (idx == LAST_IDX) begin
              state <= HOLD;
            end else begin
              idx  <= next_idx;
              sh_r <= mat_r[next_idx*W +: W];
            end
          end else begin
            sh_r    <= {sh_r[W-2:0], q_bit};
            prem_r  <= step_rem;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ZERO: begin
          quot_out    <= {(N*W){DBZ_QUOT_BIT}};
          rem_out     <= mat_r;
          div_by_zero <= 1'b1;
          state       <= HOLD;
        end
        HOLD: begin
          // First HOLD cycle raises out_valid; results are already settled by then.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
